vc_plru_ctrl: RTL

Tree-PLRU controller for the victim cache. It owns the read-modify-write sequence on the single-entry PLRU bit array (the storage block with a registered read port and a load port). It serves two request types from the victim-cache control FSM:
- TOUCH: mark a way most-recently-used.
- VICTIM: select the LRU way, then mark it MRU.

It returns the resulting way on a one-cycle response pulse.

---
 rtl/vc_plru_pkg.sv | 28 ++
 rtl/vc_plru_tree.sv | 55 +++++
 rtl/vc_plru_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/vc_plru_pkg.sv
// Shared types and tree-indexing helpers for the victim-cache PLRU controller.
package vc_plru_pkg;

    typedef enum logic {
        TOUCH  = 1'b0,
        VICTIM = 1'b1
    } plru_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        RESP   = 2'd2
    } plru_state_e;

    function automatic int left_child(input int node);
        return 2 * node + 1;
    endfunction

    function automatic int right_child(input int node);
        return 2 * node + 2;
    endfunction

    // Index of the tree node at depth lvl that lies on the path to leaf way.
    function automatic int path_node(input int lvl, input int way, input int levels);
        return ((1 << lvl) - 1) + (way >> (levels - lvl));
    endfunction

endpackage

// File: rtl/vc_plru_tree.sv
// Combinational tree-PLRU logic: walks the tree to find the LRU way and
// produces the tree bits with the chosen (or touched) way marked MRU.
module vc_plru_tree
    import vc_plru_pkg::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         bits_in,
    input  plru_op_e                    op,
    input  logic [$clog2(NUM_WAYS)-1:0] way,
    output logic [$clog2(NUM_WAYS)-1:0] sel_way,
    output logic [NUM_WAYS-2:0]         bits_out
);

    localparam int NUM_BITS = NUM_WAYS - 1;
    localparam int WAY_W    = $clog2(NUM_WAYS);

    int                 sel_node;
    logic               sel_dir;
    int                 upd_node;
    logic               upd_dir;
    logic [WAY_W-1:0]   target;

    // Descend from the root, one level per iteration, following the LRU pointers.
    always_comb begin
        sel_node = 0;
        sel_dir  = 1'b0;
        sel_way  = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            sel_dir = 1'b0;
            for (int n = 0; n < NUM_BITS; n++) begin
                if (n == sel_node) sel_dir = bits_in[n];
            end
            sel_way[WAY_W-1-lvl] = sel_dir;
            sel_node = sel_dir ? right_child(sel_node) : left_child(sel_node);
        end
    end

    assign target = (op == VICTIM) ? sel_way : way;

    // Each node on the target's path is flipped to point at the other subtree.
    always_comb begin
        bits_out = bits_in;
        upd_node = 0;
        upd_dir  = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            upd_node = path_node(lvl, int'(target), WAY_W);
            upd_dir  = target[WAY_W-1-lvl];
            for (int n = 0; n < NUM_BITS; n++) begin
                if (n == upd_node) bits_out[n] = ~upd_dir;
            end
        end
    end

endmodule

// File: rtl/vc_plru_ctrl.sv
// Victim-cache PLRU controller: read-modify-write of the PLRU bit array,
// one request every three cycles, result returned on a single-cycle pulse.
module vc_plru_ctrl
    import vc_plru_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_BITS = NUM_WAYS - 1,
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [WAY_W-1:0]    req_way,
    output logic                resp_valid,
    output logic [WAY_W-1:0]    resp_way,
    output logic                arr_read,
    output logic                arr_load,
    output logic [NUM_BITS-1:0] arr_datain,
    input  logic [NUM_BITS-1:0] arr_dataout
);

    plru_state_e        state;
    plru_state_e        state_next;
    plru_op_e           op_q;
    logic [WAY_W-1:0]   way_q;
    logic [WAY_W-1:0]   sel_way;
    logic [WAY_W-1:0]   result_way;
    logic [NUM_BITS-1:0] bits_out;

    vc_plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_tree (
        .bits_in  (arr_dataout),
        .op       (op_q),
        .way      (way_q),
        .sel_way  (sel_way),
        .bits_out (bits_out)
    );

    assign result_way = (op_q == VICTIM) ? sel_way : way_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            resp_way <= '0;
        end else begin
            state <= state_next;
            if (state == UPDATE) resp_way <= result_way;
        end
    end

    // Request fields are only meaningful once accepted, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            op_q  <= plru_op_e'(req_op);
            way_q <= req_way;
        end
    end

    // A reset in any cycle suppresses strobes so an aborted request leaves no trace.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        arr_read   = 1'b0;
        arr_load   = 1'b0;
        arr_datain = '0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !rst) begin
                    arr_read   = 1'b1;
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                if (!rst) begin
                    arr_load   = 1'b1;
                    arr_datain = bits_out;
                end
                state_next = RESP;
            end
            RESP: begin
                resp_valid = !rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
